// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings (common with the controller),
// responder error codes, mode-register fields and burst-length decode.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_LOADMODE   = 3'b000,
    CMD_REFRESH    = 3'b001,
    CMD_PRECHARGE  = 3'b010,
    CMD_ACTIVATE   = 3'b011,
    CMD_WRITE      = 3'b100,
    CMD_READ       = 3'b101,
    CMD_BURST_TERM = 3'b110,
    CMD_NOP        = 3'b111
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_NO_MODE     = 3'd1,
    ERR_BANK_IDLE   = 3'd2,
    ERR_BANK_ACTIVE = 3'd3,
    ERR_NOT_IDLE    = 3'd4,
    ERR_BAD_MODE    = 3'd5,
    ERR_AUTO_PRE    = 3'd6,
    ERR_RD_ABORT    = 3'd7
  } sdram_err_e;

  localparam int NUM_BANKS = 4;

  // Only the mode fields that change behaviour are kept (A9, CL, BL).
  typedef struct packed {
    logic       wb;
    logic [2:0] cl;
    logic [2:0] bl;
  } mode_t;

  // a = mode A[6:0]: BT must be 0, CL 2 or 3, BL not one of the reserved codes.
  function automatic logic mode_legal(input logic [6:0] a);
    return (a[3] == 1'b0) && (a[6:4] inside {3'd2, 3'd3}) &&
           (a[2:0] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b111});
  endfunction

  // Burst length in words; full page returns 0 and is handled as unbounded.
  function automatic logic [3:0] bl_len(input logic [2:0] bl);
    case (bl)
      3'b000:  return 4'd1;
      3'b001:  return 4'd2;
      3'b010:  return 4'd4;
      3'b011:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/sdram_chip_responder_bank.sv
// Per-bank open-row tracker: ACTIVATE opens a row, PRECHARGE closes the bank.
module sdram_bank_state import sdram_pkg::*; #(
  parameter int ROW_BITS = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                act_en,
  input  logic                pre_en,
  input  logic [ROW_BITS-1:0] act_row,
  output logic                active,
  output logic [ROW_BITS-1:0] row
);

  logic                active_q, active_d;
  logic [ROW_BITS-1:0] row_q, row_d;

  always_comb begin
    active_d = active_q;
    row_d    = row_q;
    if (act_en) begin
      active_d = 1'b1;
      row_d    = act_row;
    end else if (pre_en) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      row_q    <= '0;
    end else begin
      active_q <= active_d;
      row_q    <= row_d;
    end
  end

  assign active = active_q;
  assign row    = row_q;

endmodule

// File: rtl/sdram_chip_responder.sv
// SDR SDRAM chip responder: command decode, mode register, burst engine,
// CL-deep read pipeline with read-mask delay, and a word RAM on dram_dq.
module sdram_chip_responder import sdram_pkg::*; #(
  parameter int MEM_AW   = 16,
  parameter int COL_BITS = 10,
  parameter int ROW_BITS = 13
) (
  input  logic                i_clock_100_mhz,
  input  logic                i_reset,
  input  logic [1:0]          dram_ba,
  input  logic [ROW_BITS-1:0] dram_addr,
  inout  wire  [15:0]         dram_dq,
  input  logic                dram_ras,
  input  logic                dram_cas,
  input  logic                dram_we,
  input  logic                dram_ldqm,
  input  logic                dram_udqm,
  output logic                o_mode_valid,
  output logic                o_error,
  output logic [2:0]          o_err_code,
  output logic [15:0]         o_refresh_count
);

  sdram_cmd_e cmd;
  logic       a10;
  logic [COL_BITS-1:0] col_in;
  assign cmd    = sdram_cmd_e'({dram_ras, dram_cas, dram_we});
  assign a10    = dram_addr[10];
  assign col_in = dram_addr[COL_BITS-1:0];

  logic [NUM_BANKS-1:0]               bank_act, act_en, pre_en;
  logic [NUM_BANKS-1:0][ROW_BITS-1:0] bank_row;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sdram_bank_state #(.ROW_BITS(ROW_BITS)) u_bank (
      .clk    (i_clock_100_mhz),
      .rst    (i_reset),
      .act_en (act_en[b]),
      .pre_en (pre_en[b]),
      .act_row(dram_addr),
      .active (bank_act[b]),
      .row    (bank_row[b])
    );
  end

  mode_t       mode_q, mode_d;
  logic        mode_valid_q, mode_valid_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        err_pulse_q, err_pulse_d;
  logic [2:0]  err_code_q, err_code_d;
  sdram_err_e  err;

  logic                bst_act_q, bst_act_d, bst_wr_q, bst_wr_d, bst_full_q, bst_full_d;
  logic [1:0]          bst_ba_q, bst_ba_d;
  logic [COL_BITS-1:0] bst_col_q, bst_col_d;
  logic [3:0]          bst_left_q, bst_left_d, len;
  logic                len_full;

  // Stage 0 holds the access issued at the last edge; CL=3 adds stage 1.
  logic [1:0]             rd_vld_q, rd_vld_d;
  logic [1:0][MEM_AW-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]             dqm_q, oe_q, oe_d;
  logic [15:0]            dout_q;
  logic [15:0]            mem [2**MEM_AW];

  logic                start_rd, start_wr, term, iss_vld, iss_wr, cl3, rd_pending;
  logic                rd_sel_vld;
  logic [MEM_AW-1:0]   rd_sel_addr, iss_addr;
  logic [1:0]          iss_ba;
  logic [COL_BITS-1:0] iss_col;

  assign cl3         = (mode_q.cl == 3'd3);
  assign rd_sel_vld  = cl3 ? rd_vld_q[1]  : rd_vld_q[0];
  assign rd_sel_addr = cl3 ? rd_addr_q[1] : rd_addr_q[0];
  assign rd_pending  = rd_vld_q[0] | (cl3 & rd_vld_q[1]) | (|oe_q);
  assign iss_addr    = MEM_AW'({iss_ba, bank_row[iss_ba], iss_col});

  // Command decode and legality checks
  always_comb begin
    err          = ERR_NONE;
    act_en       = '0;
    pre_en       = '0;
    mode_d       = mode_q;
    mode_valid_d = mode_valid_q;
    ref_cnt_d    = ref_cnt_q;
    start_rd     = 1'b0;
    start_wr     = 1'b0;
    term         = 1'b0;
    case (cmd)
      CMD_NOP: ;
      CMD_REFRESH: begin
        if (|bank_act) err = ERR_NOT_IDLE;
        else           ref_cnt_d = ref_cnt_q + 16'd1;
      end
      CMD_PRECHARGE: begin
        for (int b = 0; b < NUM_BANKS; b++) pre_en[b] = a10 || (dram_ba == 2'(b));
        term = bst_act_q && (a10 || (dram_ba == bst_ba_q));
      end
      CMD_LOADMODE: begin
        if (|bank_act)                    err = ERR_NOT_IDLE;
        else if (!mode_legal(dram_addr[6:0])) err = ERR_BAD_MODE;
        else begin
          mode_d       = '{wb: dram_addr[9], cl: dram_addr[6:4], bl: dram_addr[2:0]};
          mode_valid_d = 1'b1;
        end
      end
      default: begin
        if (!mode_valid_q) err = ERR_NO_MODE;
        else if (cmd == CMD_BURST_TERM) term = 1'b1;
        else if (cmd == CMD_ACTIVATE) begin
          if (bank_act[dram_ba]) err = ERR_BANK_ACTIVE;
          else                   act_en[dram_ba] = 1'b1;
        end else if (!bank_act[dram_ba]) err = ERR_BANK_IDLE;
        else begin
          start_rd = (cmd == CMD_READ);
          start_wr = (cmd == CMD_WRITE);
          if (a10)                        err = ERR_AUTO_PRE;
          else if (start_wr && rd_pending) err = ERR_RD_ABORT;
        end
      end
    endcase
    err_pulse_d = (err != ERR_NONE);
    err_code_d  = (err != ERR_NONE) ? err : err_code_q;
  end

  // Burst engine: one column access per edge until length runs out or terminated
  always_comb begin
    bst_act_d  = bst_act_q;
    bst_wr_d   = bst_wr_q;
    bst_full_d = bst_full_q;
    bst_ba_d   = bst_ba_q;
    bst_col_d  = bst_col_q;
    bst_left_d = bst_left_q;
    iss_vld    = 1'b0;
    iss_wr     = 1'b0;
    iss_ba     = bst_ba_q;
    iss_col    = bst_col_q;
    len_full   = (mode_q.bl == 3'b111) && !(start_wr && mode_q.wb);
    len        = (start_wr && mode_q.wb) ? 4'd1 : bl_len(mode_q.bl);
    if (start_rd || start_wr) begin
      iss_vld    = 1'b1;
      iss_wr     = start_wr;
      iss_ba     = dram_ba;
      iss_col    = col_in;
      bst_act_d  = len_full || (len > 4'd1);
      bst_wr_d   = start_wr;
      bst_full_d = len_full;
      bst_ba_d   = dram_ba;
      bst_col_d  = col_in + COL_BITS'(1);
      bst_left_d = len - 4'd1;
    end else if (bst_act_q && !term) begin
      iss_vld    = 1'b1;
      iss_wr     = bst_wr_q;
      bst_col_d  = bst_col_q + COL_BITS'(1);
      bst_left_d = bst_left_q - 4'd1;
      if (!bst_full_q && bst_left_q == 4'd1) bst_act_d = 1'b0;
    end else if (term) begin
      bst_act_d = 1'b0;
    end
    // A WRITE drops every read word still in flight.
    rd_vld_d  = start_wr ? 2'b00 : {rd_vld_q[0], iss_vld & ~iss_wr};
    rd_addr_d = {rd_addr_q[0], iss_addr};
    oe_d      = (start_wr || !rd_sel_vld) ? 2'b00 : ~dqm_q;
  end

  always_ff @(posedge i_clock_100_mhz or posedge i_reset) begin
    if (i_reset) begin
      mode_q       <= '0;
      mode_valid_q <= 1'b0;
      ref_cnt_q    <= '0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= '0;
      bst_act_q    <= 1'b0;
      bst_wr_q     <= 1'b0;
      bst_full_q   <= 1'b0;
      bst_ba_q     <= '0;
      bst_col_q    <= '0;
      bst_left_q   <= '0;
      rd_vld_q     <= '0;
      rd_addr_q    <= '0;
      dqm_q        <= '0;
      oe_q         <= '0;
    end else begin
      mode_q       <= mode_d;
      mode_valid_q <= mode_valid_d;
      ref_cnt_q    <= ref_cnt_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      bst_act_q    <= bst_act_d;
      bst_wr_q     <= bst_wr_d;
      bst_full_q   <= bst_full_d;
      bst_ba_q     <= bst_ba_d;
      bst_col_q    <= bst_col_d;
      bst_left_q   <= bst_left_d;
      rd_vld_q     <= rd_vld_d;
      rd_addr_q    <= rd_addr_d;
      dqm_q        <= {dram_udqm, dram_ldqm};
      oe_q         <= oe_d;
    end
  end

  // RAM survives reset; read data lands in the cycle ending at edge T+CL.
  always_ff @(posedge i_clock_100_mhz) begin
    if (iss_vld && iss_wr && !dram_ldqm) mem[iss_addr][7:0]  <= dram_dq[7:0];
    if (iss_vld && iss_wr && !dram_udqm) mem[iss_addr][15:8] <= dram_dq[15:8];
    dout_q <= mem[rd_sel_addr];
  end

  assign dram_dq[7:0]  = oe_q[0] ? dout_q[7:0]  : 8'hzz;
  assign dram_dq[15:8] = oe_q[1] ? dout_q[15:8] : 8'hzz;

  assign o_mode_valid    = mode_valid_q;
  assign o_error         = err_pulse_q;
  assign o_err_code      = err_code_q;
  assign o_refresh_count = ref_cnt_q;

endmodule

// File: tb/tb_sdram_chip_responder.sv
// Directed bench for sdram_chip_responder; an undriven data bus reads back as 16'hFFFF.
module tb_sdram_chip_responder;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        ras, cas, we, ldqm, udqm;
  logic [15:0] tb_dq;
  logic        tb_oe;
  tri1  [15:0] dq;
  logic        mode_valid, err;
  logic [2:0]  err_code;
  logic [15:0] ref_cnt;
  int          total = 0;
  int          bad = 0;

  localparam logic [15:0] ZZ = 16'hFFFF;
  localparam logic [15:0] D0 = 16'hC0DE, D1 = 16'hBEEF, D2 = 16'h0F0F, D3 = 16'h7E57;

  assign dq = tb_oe ? tb_dq : 16'hzzzz;
  always #5 clk = ~clk;

  sdram_chip_responder dut (
    .i_clock_100_mhz(clk),
    .i_reset        (rst),
    .dram_ba        (ba),
    .dram_addr      (addr),
    .dram_dq        (dq),
    .dram_ras       (ras),
    .dram_cas       (cas),
    .dram_we        (we),
    .dram_ldqm      (ldqm),
    .dram_udqm      (udqm),
    .o_mode_valid   (mode_valid),
    .o_error        (err),
    .o_err_code     (err_code),
    .o_refresh_count(ref_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a command after a falling edge; it is sampled at the next rising edge
  // and the task returns on the following falling edge.
  task automatic tick(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    {ras, cas, we} = c;
    ba   = b;
    addr = a;
    @(negedge clk);
  endtask

  task automatic nop();
    tick(CMD_NOP, 2'd0, 13'd0);
  endtask

  task automatic init_seq();
    tick(CMD_PRECHARGE, 2'd0, 13'h400);
    tick(CMD_REFRESH, 2'd0, 13'd0);
    tick(CMD_LOADMODE, 2'd0, 13'h027);
  endtask

  initial begin
    rst = 1'b1; {ras, cas, we} = 3'b111; ba = '0; addr = '0;
    ldqm = 1'b0; udqm = 1'b0; tb_oe = 1'b0; tb_dq = '0;
    repeat (2) @(negedge clk);
    check("rst_mode_valid", mode_valid, 0);
    check("rst_error", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_refresh", ref_cnt, 0);
    check("rst_dq_z", dq, ZZ);
    rst = 1'b0;
    @(negedge clk);

    tick(CMD_ACTIVATE, 2'd1, 13'h0123);
    check("pre_mode_err", err, 1);
    check("pre_mode_code", err_code, 1);
    nop();
    check("err_pulse_one_cycle", err, 0);

    init_seq();
    check("init_mode_valid", mode_valid, 1);
    check("init_refresh", ref_cnt, 1);
    check("init_no_error", err, 0);

    tick(CMD_ACTIVATE, 2'd1, 13'h0123);
    check("act_ok", err, 0);
    tick(CMD_ACTIVATE, 2'd1, 13'h0042);
    check("act_twice_code", err_code, 3);

    // full word, then low byte only
    tb_dq = 16'h1234; tb_oe = 1'b1;
    tick(CMD_WRITE, 2'd1, 13'd5);
    tb_oe = 1'b0;
    tick(CMD_BURST_TERM, 2'd0, 13'd0);
    tb_dq = 16'hA55A; tb_oe = 1'b1; udqm = 1'b1;
    tick(CMD_WRITE, 2'd1, 13'd5);
    tb_oe = 1'b0; udqm = 1'b0;
    tick(CMD_BURST_TERM, 2'd0, 13'd0);

    tick(CMD_READ, 2'd1, 13'd5);
    check("rd_t1_z", dq, ZZ);
    nop();
    check("rd_masked_write", dq, 16'h125A);
    tick(CMD_BURST_TERM, 2'd0, 13'd0);
    nop();
    check("rd_term_z", dq, ZZ);

    // full-page write wrapping 1022,1023,0,1
    tb_oe = 1'b1; tb_dq = D0;
    tick(CMD_WRITE, 2'd1, 13'd1022);
    tb_dq = D1; nop();
    tb_dq = D2; nop();
    tb_dq = D3; nop();
    tb_oe = 1'b0;
    tick(CMD_BURST_TERM, 2'd0, 13'd0);

    tick(CMD_READ, 2'd1, 13'd1022);
    check("fp_t1_z", dq, ZZ);
    nop();
    check("fp_col1022", dq, D0);
    nop();
    check("fp_col1023", dq, D1);
    tick(CMD_BURST_TERM, 2'd0, 13'd0);
    check("fp_col0_wrap", dq, D2);
    nop();
    check("fp_term_z", dq, ZZ);

    // read mask latency 2: udqm at T+1 blanks the high byte of the T+3 word
    tick(CMD_READ, 2'd1, 13'd1022);
    udqm = 1'b1; nop();
    check("dqm_unmasked", dq, D0);
    udqm = 1'b0;
    tick(CMD_BURST_TERM, 2'd0, 13'd0);
    check("dqm_hi_z", dq, {8'hFF, D1[7:0]});
    nop();
    check("dqm_end_z", dq, ZZ);

    tick(CMD_READ, 2'd2, 13'd5);
    check("rd_idle_err", err, 1);
    check("rd_idle_code", err_code, 2);
    nop();
    check("rd_idle_z1", dq, ZZ);
    nop();
    check("rd_idle_z2", dq, ZZ);

    tick(CMD_REFRESH, 2'd0, 13'd0);
    check("ref_active_code", err_code, 4);
    check("ref_active_cnt", ref_cnt, 1);

    tick(CMD_READ, 2'd1, 13'h405);
    check("autopre_code", err_code, 6);
    nop();
    check("autopre_data", dq, 16'h125A);
    tick(CMD_BURST_TERM, 2'd0, 13'd0);
    nop();

    // WRITE (fully masked) while read data is on the bus
    tick(CMD_READ, 2'd1, 13'd1022);
    nop();
    check("abort_rd_data", dq, D0);
    ldqm = 1'b1; udqm = 1'b1;
    tick(CMD_WRITE, 2'd1, 13'd500);
    check("abort_code", err_code, 7);
    check("abort_flush_z", dq, ZZ);
    tick(CMD_BURST_TERM, 2'd0, 13'd0);
    ldqm = 1'b0; udqm = 1'b0;
    check("abort_still_z", dq, ZZ);

    // reset in the middle of a full-page read
    tick(CMD_READ, 2'd1, 13'd1022);
    nop();
    check("mid_rd_data", dq, D0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_z", dq, ZZ);
    check("async_rst_mode", mode_valid, 0);
    check("async_rst_cnt", ref_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    tick(CMD_PRECHARGE, 2'd0, 13'h400);
    tick(CMD_REFRESH, 2'd0, 13'd0);
    tick(CMD_LOADMODE, 2'd0, 13'h02F);
    check("bad_mode_code", err_code, 5);
    check("bad_mode_not_valid", mode_valid, 0);
    tick(CMD_LOADMODE, 2'd0, 13'h027);
    check("reinit_valid", mode_valid, 1);
    check("reinit_refresh", ref_cnt, 1);
    tick(CMD_ACTIVATE, 2'd1, 13'h0123);
    tick(CMD_READ, 2'd1, 13'd5);
    nop();
    check("retained_word", dq, 16'h125A);
    tick(CMD_BURST_TERM, 2'd0, 13'd0);
    nop();

    // CL=3, BL=4
    tick(CMD_PRECHARGE, 2'd0, 13'h400);
    tick(CMD_LOADMODE, 2'd0, 13'h032);
    check("cl3_mode_ok", err, 0);
    tick(CMD_ACTIVATE, 2'd1, 13'h0123);
    tick(CMD_READ, 2'd1, 13'd1022);
    nop();
    check("cl3_t2_z", dq, ZZ);
    nop();
    check("cl3_col1022", dq, D0);
    nop();
    check("cl3_col1023", dq, D1);
    nop();
    check("cl3_col0", dq, D2);
    nop();
    check("cl3_col1", dq, D3);
    nop();
    check("bl4_end_z", dq, ZZ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
